jedro_1_dmem: RTL and testbench
===============================

// Module: jedro_1_dmem
// PURPOSE
//  Data-memory responder: the slave end of the core's data interface (req/gnt/rvalid).
//  Holds a word-organised SRAM and accepts byte-enabled reads and writes.
//  Returns one response per granted request, with an error flag.
//  Sits beside jedro_1_top and serves as the on-chip data RAM.
//  Also serves as the bus model in the core's testbenches.
// PARAMETERS
//  DATA_WIDTH   32            data bus width; byte enables are DATA_WIDTH/8 = 4
//  ADDR_WIDTH   10            word-address bits; capacity 4*2**ADDR_WIDTH bytes (4 KiB)
//  BASE_ADDR    32'h0000_0000 byte address of word 0; must be aligned to the capacity
//  WAIT_CYCLES  0             request cycles stalled before grant (0..15)
// PORTS
//  clk_i          in   1   clock; all state updates on the rising edge
//  rstn_i         in   1   reset, synchronous, active-low
//  data_req_i     in   1   request valid; addr/we/be/wdata stable while req && !gnt
//  data_gnt_o     out  1   request accepted this cycle (address phase ends)
//  data_rvalid_o  out  1   response valid, exactly 1 cycle per grant
//  data_we_i      in   1   1 = write, 0 = read
//  data_be_i      in   4   byte enables; bit n covers data bits [8n+7:8n]
//  data_addr_i    in   32  byte address
//  data_wdata_i   in   32  write data
//  data_rdata_o   out  32  read data, valid only with data_rvalid_o
//  data_err_o     out  1   response error, valid only with data_rvalid_o
// BEHAVIOUR
//  Reset (rstn_i=0 at an edge):
//   - rvalid_o=0, rdata_o=0, err_o=0; wait counter=0; state=IDLE.
//   - data_gnt_o is forced 0 while rstn_i=0.
//   - SRAM contents are not cleared. A pending response is dropped and never issued.
//  States: IDLE (no response due next cycle), RESP (rvalid_o=1 this cycle).
//  Wait counter wcnt (4 bit):
//   - Increments each cycle that req_i=1 and gnt_o=0.
//   - Clears on a grant, or when req_i=0.
//  Grant: gnt_o = rstn_i && req_i && (wcnt == WAIT_CYCLES). Combinational.
//   - Valid in IDLE or RESP, so back-to-back requests are accepted every cycle.
//   - Full throughput when WAIT_CYCLES=0.
//   - If req_i drops before the grant, no transaction occurs.
//  Error check at the grant edge. err=1 if any of:
//   - addr_i[1:0] != 0;
//   - be_i == 0;
//   - addr_i outside [BASE_ADDR, BASE_ADDR + 4*2**ADDR_WIDTH).
//  Word index = addr_i[ADDR_WIDTH+1:2].
//  Write grant, err=0: each byte with be_i[n]=1 is written at that edge; other bytes unchanged.
//  Read grant, err=0: rdata for the next cycle = whole word at index (be_i ignored).
//  Write or error response: rdata_o=0. Errored writes leave the SRAM unchanged.
//  Latency: response in the cycle after the grant.
//   - Next state = RESP if a grant occurred this cycle, else IDLE.
//   - rdata_o/err_o are registered; they read 0 whenever rvalid_o=0.
//  Ordering: responses return in grant order; at most one response is outstanding.
//  Write then read of the same word on consecutive grants: the read returns the new data.
//  Simultaneous rvalid_o and gnt_o (RESP with a new request) is legal; the response
//   belongs to the previous grant.
// TESTING
//  1. WAIT_CYCLES=0: write 32'hDEADBEEF @0x10 be=F, then read @0x10
//     -> gnt in the req cycle each time; rvalid next cycle; rdata=DEADBEEF, err=0.
//  2. Byte write be=4'b0010 wdata=32'h0000_5500 over DEADBEEF @0x10, then read
//     -> rdata=32'hDEAD55EF.
//  3. WAIT_CYCLES=2, read held 3 cycles -> gnt only in the 3rd req cycle; rvalid in the 4th.
//     req dropped after 1 cycle -> no gnt, no rvalid.
//  4. Errors: read @0x12; write be=0; read @BASE+0x1000
//     -> err=1, rdata=0 each time; a later read @0x0 shows the SRAM unchanged.
//  5. 4 back-to-back writes then 4 reads @0x0..0xC, req held high (WAIT_CYCLES=0)
//     -> 8 consecutive gnt, 8 consecutive rvalid, data in order.
//  6. rstn_i=0 in the cycle after a read grant -> rvalid stays 0, no response;
//     data written earlier is still readable after reset.

Source files
------------

// File: rtl/jedro_1_dmem_if.sv
// Core data bus (req/gnt/rvalid). Signal suffixes are from the memory's point of view.
interface jedro_1_dmem_if #(
    parameter int DATA_WIDTH = 32
);
    logic                      data_req_i;
    logic                      data_gnt_o;
    logic                      data_rvalid_o;
    logic                      data_we_i;
    logic [DATA_WIDTH/8-1:0]   data_be_i;
    logic [31:0]               data_addr_i;
    logic [DATA_WIDTH-1:0]     data_wdata_i;
    logic [DATA_WIDTH-1:0]     data_rdata_o;
    logic                      data_err_o;

    modport slave (
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );

    modport master (
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o, data_err_o
    );
endinterface

// File: rtl/jedro_1_dmem.sv
// Data-memory responder: word-organised SRAM with byte enables behind a req/gnt/rvalid slave port.
// One registered response per grant; optional fixed wait states before the grant.
module jedro_1_dmem #(
    parameter int          DATA_WIDTH  = 32,
    parameter int          ADDR_WIDTH  = 10,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 0
) (
    input  logic           clk_i,
    input  logic           rstn_i,
    jedro_1_dmem_if.slave  data
);
    localparam int          BE_W   = DATA_WIDTH / 8;
    localparam int          DEPTH  = 2 ** ADDR_WIDTH;
    localparam logic [32:0] CAP    = 33'(DEPTH) << 2;
    localparam logic [3:0]  WAIT_N = 4'(WAIT_CYCLES);

    typedef enum logic {IDLE, RESP} state_t;

    state_t                  state_q, state_d;
    logic [3:0]              wcnt_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    gnt;
    logic                    err_c;
    logic [32:0]             offset;
    logic [ADDR_WIDTH-1:0]   idx;

    assign idx = data.data_addr_i[ADDR_WIDTH+1:2];

    // Below-base addresses wrap to a huge offset, so one compare covers both ends.
    assign offset = {1'b0, data.data_addr_i} - {1'b0, BASE_ADDR};

    always_comb begin
        err_c = 1'b0;
        if (data.data_addr_i[1:0] != 2'b00) err_c = 1'b1;
        if (data.data_be_i == '0)           err_c = 1'b1;
        if (offset >= CAP)                  err_c = 1'b1;
    end

    assign gnt = rstn_i && data.data_req_i && (wcnt_q == WAIT_N);

    always_comb begin
        state_d            = IDLE;
        data.data_gnt_o    = gnt;
        data.data_rvalid_o = 1'b0;
        data.data_rdata_o  = '0;
        data.data_err_o    = 1'b0;
        if (gnt) state_d = RESP;
        // Gating with reset drops a response that was due while reset is asserted.
        if (rstn_i && state_q == RESP) begin
            data.data_rvalid_o = 1'b1;
            data.data_rdata_o  = rdata_q;
            data.data_err_o    = err_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= (data.data_req_i && !gnt) ? wcnt_q + 4'd1 : 4'd0;
            rdata_q <= (gnt && !err_c && !data.data_we_i) ? mem[idx] : '0;
            err_q   <= gnt && err_c;
        end
    end

    // SRAM array is never reset.
    always_ff @(posedge clk_i) begin
        if (gnt && data.data_we_i && !err_c) begin
            for (int b = 0; b < BE_W; b++) begin
                if (data.data_be_i[b]) mem[idx][8*b +: 8] <= data.data_wdata_i[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_jedro_1_dmem.sv
// Directed bench for jedro_1_dmem: a zero-wait instance and a two-wait-state instance.
module tb_jedro_1_dmem;
    logic clk = 1'b0;
    logic rstn;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    jedro_1_dmem_if #(.DATA_WIDTH(32)) bus_a ();
    jedro_1_dmem_if #(.DATA_WIDTH(32)) bus_b ();

    jedro_1_dmem #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_CYCLES(0))
        u_dut0 (.clk_i(clk), .rstn_i(rstn), .data(bus_a.slave));

    jedro_1_dmem #(.DATA_WIDTH(32), .ADDR_WIDTH(10), .BASE_ADDR(32'h0), .WAIT_CYCLES(2))
        u_dut2 (.clk_i(clk), .rstn_i(rstn), .data(bus_b.slave));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drv_a(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus_a.data_req_i   = req;
        bus_a.data_we_i    = we;
        bus_a.data_be_i    = be;
        bus_a.data_addr_i  = addr;
        bus_a.data_wdata_i = wdata;
    endtask

    task automatic drv_b(input logic req, input logic we, input logic [3:0] be,
                         input logic [31:0] addr, input logic [31:0] wdata);
        bus_b.data_req_i   = req;
        bus_b.data_we_i    = we;
        bus_b.data_be_i    = be;
        bus_b.data_addr_i  = addr;
        bus_b.data_wdata_i = wdata;
    endtask

    // Advance to just after the next rising edge (input drive point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] burst_val [4];

    initial begin
        burst_val[0] = 32'hA000_0000;
        burst_val[1] = 32'hA111_1111;
        burst_val[2] = 32'hA222_2222;
        burst_val[3] = 32'hA333_3333;

        // Reset with a request pending: no grant while rstn is low.
        rstn = 1'b0;
        drv_a(1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        drv_b(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
        @(negedge clk);
        chk("rst_gnt", 32'(bus_a.data_gnt_o), 32'd0);
        tick();
        drv_a(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
        @(negedge clk);
        chk("rst_rvalid", 32'(bus_a.data_rvalid_o), 32'd0);
        chk("rst_rdata",  bus_a.data_rdata_o, 32'd0);
        chk("rst_err",    32'(bus_a.data_err_o), 32'd0);
        tick();
        rstn = 1'b1;
        @(negedge clk);
        chk("idle_rvalid", 32'(bus_a.data_rvalid_o), 32'd0);

        // Full-word write then read.
        tick(); drv_a(1'b1, 1'b1, 4'hF, 32'h10, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("w1_gnt", 32'(bus_a.data_gnt_o), 32'd1);
        tick(); drv_a(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        @(negedge clk);
        chk("r1_gnt",     32'(bus_a.data_gnt_o), 32'd1);
        chk("w1_rvalid",  32'(bus_a.data_rvalid_o), 32'd1);
        chk("w1_rdata",   bus_a.data_rdata_o, 32'd0);
        chk("w1_err",     32'(bus_a.data_err_o), 32'd0);
        tick(); drv_a(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
        @(negedge clk);
        chk("r1_rvalid", 32'(bus_a.data_rvalid_o), 32'd1);
        chk("r1_rdata",  bus_a.data_rdata_o, 32'hDEAD_BEEF);
        chk("r1_err",    32'(bus_a.data_err_o), 32'd0);

        // Single-byte write merges into the existing word.
        tick(); drv_a(1'b1, 1'b1, 4'b0010, 32'h10, 32'h0000_5500);
        @(negedge clk);
        chk("w2_gnt", 32'(bus_a.data_gnt_o), 32'd1);
        tick(); drv_a(1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
        @(negedge clk);
        chk("w2_rvalid", 32'(bus_a.data_rvalid_o), 32'd1);
        tick(); drv_a(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
        @(negedge clk);
        chk("r2_rdata", bus_a.data_rdata_o, 32'hDEAD_55EF);

        // Errors: misaligned, empty byte mask, out of range (aliases word 0).
        tick(); drv_a(1'b1, 1'b1, 4'hF, 32'h0, 32'h1122_3344);
        tick(); drv_a(1'b1, 1'b0, 4'hF, 32'h12, 32'h0);
        @(negedge clk);
        chk("e1_gnt", 32'(bus_a.data_gnt_o), 32'd1);
        tick(); drv_a(1'b1, 1'b1, 4'h0, 32'h0, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("e1_err",   32'(bus_a.data_err_o), 32'd1);
        chk("e1_rdata", bus_a.data_rdata_o, 32'd0);
        tick(); drv_a(1'b1, 1'b1, 4'hF, 32'h1000, 32'hFFFF_FFFF);
        @(negedge clk);
        chk("e2_err", 32'(bus_a.data_err_o), 32'd1);
        tick(); drv_a(1'b1, 1'b0, 4'hF, 32'h1000, 32'h0);
        @(negedge clk);
        chk("e3_err", 32'(bus_a.data_err_o), 32'd1);
        tick(); drv_a(1'b1, 1'b0, 4'hF, 32'h0, 32'h0);
        @(negedge clk);
        chk("e4_err",   32'(bus_a.data_err_o), 32'd1);
        chk("e4_rdata", bus_a.data_rdata_o, 32'd0);
        tick(); drv_a(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
        @(negedge clk);
        chk("unch_err",   32'(bus_a.data_err_o), 32'd0);
        chk("unch_rdata", bus_a.data_rdata_o, 32'h1122_3344);

        // Back-to-back: 4 writes then 4 reads, req held high.
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i < 4) drv_a(1'b1, 1'b1, 4'hF, 32'(4 * i), burst_val[i]);
            else       drv_a(1'b1, 1'b0, 4'hF, 32'(4 * (i - 4)), 32'h0);
            @(negedge clk);
            chk($sformatf("b2b_gnt%0d", i), 32'(bus_a.data_gnt_o), 32'd1);
            chk($sformatf("b2b_rv%0d", i), 32'(bus_a.data_rvalid_o), (i == 0) ? 32'd0 : 32'd1);
            if (i >= 5) chk($sformatf("b2b_rd%0d", i - 5), bus_a.data_rdata_o, burst_val[i - 5]);
        end
        tick(); drv_a(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
        @(negedge clk);
        chk("b2b_rv8", 32'(bus_a.data_rvalid_o), 32'd1);
        chk("b2b_rd3", bus_a.data_rdata_o, burst_val[3]);

        // Reset right after a read grant drops the response.
        tick(); drv_a(1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
        @(negedge clk);
        chk("rr_gnt", 32'(bus_a.data_gnt_o), 32'd1);
        tick(); rstn = 1'b0;
        @(negedge clk);
        chk("rr_gnt_in_rst", 32'(bus_a.data_gnt_o), 32'd0);
        chk("rr_rvalid0",    32'(bus_a.data_rvalid_o), 32'd0);
        chk("rr_rdata0",     bus_a.data_rdata_o, 32'd0);
        tick(); drv_a(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
        @(negedge clk);
        chk("rr_rvalid1", 32'(bus_a.data_rvalid_o), 32'd0);
        tick(); rstn = 1'b1;
        @(negedge clk);
        chk("rr_rvalid2", 32'(bus_a.data_rvalid_o), 32'd0);
        tick(); drv_a(1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
        tick(); drv_a(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
        @(negedge clk);
        chk("rr_keep_rv", 32'(bus_a.data_rvalid_o), 32'd1);
        chk("rr_keep_rd", bus_a.data_rdata_o, burst_val[1]);

        // Two wait states: write held 3 cycles, then read held 3 cycles.
        for (int i = 0; i < 3; i++) begin
            tick(); drv_b(1'b1, 1'b1, 4'hF, 32'h8, 32'hCAFE_F00D);
            @(negedge clk);
            chk($sformatf("ws_wgnt%0d", i), 32'(bus_b.data_gnt_o), (i == 2) ? 32'd1 : 32'd0);
            chk($sformatf("ws_wrv%0d", i), 32'(bus_b.data_rvalid_o), 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            tick(); drv_b(1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
            @(negedge clk);
            chk($sformatf("ws_rgnt%0d", i), 32'(bus_b.data_gnt_o), (i == 2) ? 32'd1 : 32'd0);
            chk($sformatf("ws_rrv%0d", i), 32'(bus_b.data_rvalid_o), (i == 0) ? 32'd1 : 32'd0);
        end
        tick(); drv_b(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
        @(negedge clk);
        chk("ws_rv",   32'(bus_b.data_rvalid_o), 32'd1);
        chk("ws_rd",   bus_b.data_rdata_o, 32'hCAFE_F00D);

        // Abandoned request: no grant, no response, counter restarts.
        tick(); drv_b(1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
        @(negedge clk);
        chk("ab_gnt", 32'(bus_b.data_gnt_o), 32'd0);
        tick(); drv_b(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
        @(negedge clk);
        chk("ab_rv0", 32'(bus_b.data_rvalid_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(); drv_b(1'b1, 1'b0, 4'hF, 32'h8, 32'h0);
            @(negedge clk);
            chk($sformatf("ab_regnt%0d", i), 32'(bus_b.data_gnt_o), (i == 2) ? 32'd1 : 32'd0);
            chk($sformatf("ab_rerv%0d", i), 32'(bus_b.data_rvalid_o), 32'd0);
        end
        tick(); drv_b(1'b0, 1'b0, 4'hF, 32'h0, 32'h0);
        @(negedge clk);
        chk("ab_rv1", 32'(bus_b.data_rvalid_o), 32'd1);
        chk("ab_rd1", bus_b.data_rdata_o, 32'hCAFE_F00D);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
